// File: rtl/encrypt4_sched_ctrl.sv
// Sequencing controller around a registered encrypt_function_4 datapath: takes 60-bit words,
// supplies LFSR keys, presents 78-bit ciphertext. Optional LFSR reseed port: ENC4_SEED_LOAD_EN.
module encrypt4_sched_ctrl #(
    parameter logic [10:0] SEED11 = 11'h5A5,
    parameter logic [5:0]  SEED6  = 6'h2D,
    parameter int          CNT_W  = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [59:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [77:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
`ifdef ENC4_SEED_LOAD_EN
    ,
    input  logic             seed_load,
    input  logic [10:0]      seed_11,
    input  logic [5:0]       seed_6
`endif
);

    typedef enum logic [1:0] {IDLE, ENC, HOLD} state_t;

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [10:0] SEED11_EFF = (SEED11 == 11'h0) ? 11'h001 : SEED11;
    localparam logic [5:0]  SEED6_EFF  = (SEED6 == 6'h0)   ? 6'h01   : SEED6;

    state_t           state_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [10:0]      lfsr11_q, lfsr11_d;
    logic [5:0]       lfsr6_q, lfsr6_d;
    logic [59:0]      data_h_q;
    logic [10:0]      r11_h_q;
    logic [5:0]       r6_h_q;
    logic [77:0]      enc_q;
    logic [59:0]      b_w;
    logic [60:0]      sum_w;

    assign lfsr11_d = {lfsr11_q[9:0], lfsr11_q[10] ^ lfsr11_q[8]};
    assign lfsr6_d  = {lfsr6_q[4:0], lfsr6_q[5] ^ lfsr6_q[4]};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            lfsr11_q    <= SEED11_EFF;
            lfsr6_q     <= SEED6_EFF;
            data_h_q    <= '0;
            r11_h_q     <= '0;
            r6_h_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ENC4_SEED_LOAD_EN
                    if (seed_load) begin
                        lfsr11_q <= (seed_11 == 11'h0) ? 11'h001 : seed_11;
                        lfsr6_q  <= (seed_6 == 6'h0) ? 6'h01 : seed_6;
                    end else
`endif
                    if (in_valid) begin
                        data_h_q   <= in_data;
                        r11_h_q    <= lfsr11_q;
                        r6_h_q     <= lfsr6_q;
                        lfsr11_q   <= lfsr11_d;
                        lfsr6_q    <= lfsr6_d;
                        cnt_q      <= cnt_q + 1'b1;
                        state_q    <= ENC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ENC: begin
                    state_q     <= HOLD;
                    out_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Encryptor datapath: unreset register, sampled only in ENC; carry lands in sum bit 60.
    assign b_w   = {r11_h_q[4:0], ~r11_h_q, r11_h_q, ~r11_h_q, ~r11_h_q, r11_h_q};
    assign sum_w = {1'b0, data_h_q} + {1'b0, b_w};

    always_ff @(posedge Clk) begin
        if (state_q == ENC)
            enc_q <= {r11_h_q, sum_w, r6_h_q};
    end

`ifdef ENC4_SEED_LOAD_EN
    assign in_ready  = in_ready_q & ~seed_load;
`else
    assign in_ready  = in_ready_q;
`endif
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? enc_q : 78'h0;
    assign busy      = busy_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_encrypt4_sched_ctrl.sv
// Directed + randomized bench for encrypt4_sched_ctrl against an arithmetic reference model.
module tb_encrypt4_sched_ctrl;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [59:0]   in_data;
    logic [77:0]   out_data;
    logic [CW-1:0] word_cnt;
`ifdef ENC4_SEED_LOAD_EN
    logic          seed_load;
    logic [10:0]   seed_11;
    logic [5:0]    seed_6;
`endif

    int checks = 0;
    int failures = 0;

    logic [10:0] m11;
    logic [5:0]  m6;
    int          m_cnt;
    logic [77:0] got;

    encrypt4_sched_ctrl #(.CNT_W(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .word_cnt(word_cnt)
`ifdef ENC4_SEED_LOAD_EN
        , .seed_load(seed_load), .seed_11(seed_11), .seed_6(seed_6)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [59:0] rnd60();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[59:0];
    endfunction

    // Ciphertext = {r11, data + B, r6} with B built from 11-bit key fields, full 61-bit sum.
    function automatic logic [77:0] enc_model(input logic [59:0] d, input logic [10:0] r,
                                              input logic [5:0] r6);
        logic [59:0] b;
        logic [60:0] s;
        b = {r[4:0], ~r, r, ~r, ~r, r};
        s = 61'(d) + 61'(b);
        return {r, s, r6};
    endfunction

    task automatic model_reset();
        m11 = 11'h5A5;
        m6 = 6'h2D;
        m_cnt = 0;
    endtask

    // One full word transaction; hold = cycles out_ready stays low in HOLD, junk = keep in_valid high.
    task automatic send(input logic [59:0] d, input int hold, input bit junk, output logic [77:0] res);
        logic [77:0] e;
        e = enc_model(d, m11, m6);
        in_data = d;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        chk("in_ready_idle", 78'(in_ready), 78'd1);
        step();
        m_cnt = (m_cnt + 1) % (1 << CW);
        m11 = {m11[9:0], m11[10] ^ m11[8]};
        m6 = {m6[4:0], m6[5] ^ m6[4]};
        in_valid = junk;
        in_data = rnd60();
        chk("ov_after_accept", 78'(out_valid), 78'd0);
        chk("busy_enc", 78'(busy), 78'd1);
        chk("cnt_accept", 78'(word_cnt), 78'(m_cnt));
        step();
        chk("ov_hold", 78'(out_valid), 78'd1);
        chk("out_data", out_data, e);
        chk("in_ready_hold", 78'(in_ready), 78'd0);
        res = out_data;
        for (int i = 0; i < hold; i++) begin
            in_data = rnd60();
            step();
            chk("ov_stall", 78'(out_valid), 78'd1);
            chk("od_stall", out_data, e);
            chk("in_ready_stall", 78'(in_ready), 78'd0);
        end
        out_ready = 1'b1;
        step();
        chk("ov_release", 78'(out_valid), 78'd0);
        chk("od_zero", out_data, 78'd0);
        chk("in_ready_back", 78'(in_ready), 78'd1);
        chk("busy_idle", 78'(busy), 78'd0);
        chk("cnt_release", 78'(word_cnt), 78'(m_cnt));
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
`ifdef ENC4_SEED_LOAD_EN
        seed_load = 1'b0;
        seed_11 = '0;
        seed_6 = '0;
`endif
        model_reset();
        #12;
        chk("rst_in_ready", 78'(in_ready), 78'd1);
        chk("rst_out_valid", 78'(out_valid), 78'd0);
        chk("rst_busy", 78'(busy), 78'd0);
        chk("rst_cnt", 78'(word_cnt), 78'd0);
        chk("rst_out_data", out_data, 78'd0);
        Rst_n = 1'b1;
        step();

        // first two words expose the seed and the first LFSR advance
        send(60'h0, 0, 1'b0, got);
        chk("t1_r11", 78'(got[77:67]), 78'h5A5);
        chk("t1_r6", 78'(got[5:0]), 78'h2D);
        send(rnd60(), 0, 1'b0, got);
        chk("t2_r11", 78'(got[77:67]), 78'h34A);
        chk("t2_r6", 78'(got[5:0]), 78'h1B);

        // randomized traffic, long enough to wrap the counter
        for (int n = 0; n < 18; n++)
            send(rnd60(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);

        // long stall with in_valid held high
        send(rnd60(), 10, 1'b1, got);

        // carry out of the 60-bit add
        Rst_n = 1'b0;
        #2;
        Rst_n = 1'b1;
        model_reset();
        step();
        send(60'hFFF_FFFF_FFFF_FFFF, 1, 1'b0, got);
        chk("t3_carry", 78'(got[66]), 78'd1);

        // reset in ENC drops the word
        in_data = rnd60();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t5_busy_pre", 78'(busy), 78'd1);
        Rst_n = 1'b0;
        #2;
        chk("t5_ov_rst", 78'(out_valid), 78'd0);
        chk("t5_cnt_rst", 78'(word_cnt), 78'd0);
        Rst_n = 1'b1;
        model_reset();
        step();
        chk("t5_ov_after", 78'(out_valid), 78'd0);
        chk("t5_busy_after", 78'(busy), 78'd0);
        send(rnd60(), 0, 1'b0, got);
        chk("t5_r11", 78'(got[77:67]), 78'h5A5);
        chk("t5_r6", 78'(got[5:0]), 78'h2D);

`ifdef ENC4_SEED_LOAD_EN
        seed_load = 1'b1;
        seed_11 = 11'h0;
        seed_6 = 6'h3F;
        in_valid = 1'b1;
        in_data = rnd60();
        #1;
        chk("t6_in_ready", 78'(in_ready), 78'd0);
        step();
        seed_load = 1'b0;
        in_valid = 1'b0;
        chk("t6_busy", 78'(busy), 78'd0);
        chk("t6_cnt", 78'(word_cnt), 78'(m_cnt));
        m11 = 11'h001;
        m6 = 6'h3F;
        send(rnd60(), 0, 1'b0, got);
        chk("t6_r11", 78'(got[77:67]), 78'h001);
        chk("t6_r6", 78'(got[5:0]), 78'h3F);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
